dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port, byte-wide synchronous data RAM between NCORES processor cores.
- Each core raises a read or write request with address and data; the block grants one core at a time in round-robin order.
- It sequences the RAM access, returns read data and pulses a per-core ack.
- Sits between the core load/store units and the data RAM, alongside the instruction-memory controller.

Parameters:
- NCORES, 2, number of requesting cores (≥1).
- AW, 8, RAM address width.
- DW, 8, RAM data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rden  in  NCORES  per-core read request, level, held until ack.
- wren  in  NCORES  per-core write request, level, held until ack.
- Address  in  NCORES*AW  per-core address, core i at [i*AW +: AW].
- Din  in  NCORES*DW  per-core write data, core i at [i*DW +: DW].
- RAMq  in  DW  RAM read data, valid the cycle after RAM samples the address.
- acq  out  NCORES  one-hot ack pulse, one cycle, to the served core.
- Dq  out  DW  read data of the last completed read, registered, held until the next read completes.
- RAMAddress  out  AW  RAM address, registered.
- RAMDin  out  DW  RAM write data, registered.
- RAMwren  out  1  RAM write enable, registered.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - acq, Dq, RAMAddress, RAMDin and RAMwren all 0.
  - Round-robin pointer last=NCORES-1, so core 0 has first priority.
  - Reset mid-transaction abandons it immediately: no ack, RAMwren low the next cycle.
- Request of core i: req[i] = rden[i] | wren[i]. If both are set, the request is a write.
- Winner selection: the first i with req[i]=1 scanning last+1, last+2, … modulo NCORES.
- States: IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise, on the edge: latch the winner index; RAMAddress<=Address[win]; RAMDin<=Din[win]; RAMwren<=wren[win]; go to ACCESS.
- ACCESS: RAM inputs are stable for this cycle and the RAM samples them on the closing edge. On that edge RAMwren<=0 and state goes to WAIT.
- WAIT: RAMq is valid. On the edge:
  - If the access was a read, Dq<=RAMq; for a write, Dq is unchanged.
  - acq[win]<=1; go to DONE.
- DONE: acq[win] is high for exactly this cycle. On the edge: acq<=0; last<=win; go to IDLE.
- Requester contract: deassert the request on the edge that ends the ack cycle. A request still asserted in IDLE is treated as a new transaction.
- Latency: request sampled in IDLE at edge 0 gives acq high in the cycle after edge 2 (3 cycles). Throughput is one transaction per 4 cycles.
- Address and Din changes after edge 0 are ignored. A request withdrawn mid-transaction still completes and still acks.
- No new arbitration happens outside IDLE. The pointer advances only on completion, so each waiting core is served within NCORES transactions.
- NCORES=1: the pointer is constant and behaviour is otherwise identical.
- acq is always zero or one-hot, never multi-hot.

Decomposition:
- Shared package dmem_pkg:
  - State encoding constants IDLE=0, ACCESS=1, WAIT=2, DONE=3 (2-bit).
  - Default AW/DW values.
  - Index width function clog2(NCORES), minimum 1.
- One sub-module, rr_picker: combinational round-robin select from req vector and pointer, outputting win index and valid. It is reused later by the I/O arbiter.
- The FSM, datapath registers and pointer stay in dmem_arbiter.

Test Plan:
- Single read: reset; RAM preloaded mem[0x10]=0xA5; core0 rden=1, Address=0x10 -> RAMAddress=0x10 at ACCESS, acq=2'b01 exactly 3 cycles after request, Dq=0xA5, RAMwren never high.
- Single write then read: core1 wren=1, Address=0x20, Din=0x3C -> RAMwren high exactly 1 cycle with RAMAddress=0x20, RAMDin=0x3C, acq=2'b10; then core1 reads 0x20 -> Dq=0x3C.
- Contention: both cores request continuously from reset -> grant order core0, core1, core0, core1; acq one-hot every 4 cycles.
- Read+write simultaneous on one core: rden[0]=wren[0]=1, Din=0x77, Address=0x05 -> treated as write, mem[0x05]=0x77, Dq unchanged.
- Reset mid-operation: assert rst during WAIT of a core0 read -> next cycle state IDLE, acq=0, RAMwren=0, Dq=0; the next contention round grants core0 first.
- Withdrawn request: core0 drops rden in ACCESS -> transaction completes, acq[0] still pulses, and the next IDLE does not start a new core0 transaction.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  // Width of a core index; a single core still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rtl/dmem_arbiter_rr_picker.sv - combinational round-robin winner select
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          valid
);

  // Scan last+1, last+2, ... modulo N and take the first requester
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[(int'(last) + k) % N]) begin
        valid = 1'b1;
        win   = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of one byte-wide sync RAM between cores
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    rden,
  input  logic [NCORES-1:0]    wren,
  input  logic [NCORES*AW-1:0] Address,
  input  logic [NCORES*DW-1:0] Din,
  input  logic [DW-1:0]        RAMq,
  output logic [NCORES-1:0]    acq,
  output logic [DW-1:0]        Dq,
  output logic [AW-1:0]        RAMAddress,
  output logic [DW-1:0]        RAMDin,
  output logic                 RAMwren
);

  localparam int IW = idx_width(NCORES);

  state_t            state;
  logic [IW-1:0]     win_q;
  logic [IW-1:0]     last;
  logic              is_write;
  logic [NCORES-1:0] req;
  logic [IW-1:0]     pick;
  logic              pick_valid;

  // A core requests on either enable; write wins when both are set
  always_comb begin
    req = rden | wren;
  end

  rr_picker #(
    .N  (NCORES),
    .IW (IW)
  ) u_picker (
    .req   (req),
    .last  (last),
    .win   (pick),
    .valid (pick_valid)
  );

  // Transaction sequencer: arbitrate in IDLE, drive RAM, capture data, ack, advance pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_q      <= '0;
      last       <= IW'(NCORES - 1);
      is_write   <= 1'b0;
      acq        <= '0;
      Dq         <= '0;
      RAMAddress <= '0;
      RAMDin     <= '0;
      RAMwren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win_q      <= pick;
            RAMAddress <= Address[pick*AW +: AW];
            RAMDin     <= Din[pick*DW +: DW];
            RAMwren    <= wren[pick];
            is_write   <= wren[pick];
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          RAMwren <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (!is_write) begin
            Dq <= RAMq;
          end
          acq[win_q] <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          acq   <= '0;
          last  <= win_q;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural RAM
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rden = '0;
  logic [1:0]  wren = '0;
  logic [15:0] Address = '0;
  logic [15:0] Din = '0;
  logic [7:0]  RAMq = '0;
  logic [1:0]  acq;
  logic [7:0]  Dq;
  logic [7:0]  RAMAddress;
  logic [7:0]  RAMDin;
  logic        RAMwren;

  dmem_arbiter #(.NCORES(2), .AW(8), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rden       (rden),
    .wren       (wren),
    .Address    (Address),
    .Din        (Din),
    .RAMq       (RAMq),
    .acq        (acq),
    .Dq         (Dq),
    .RAMAddress (RAMAddress),
    .RAMDin     (RAMDin),
    .RAMwren    (RAMwren)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read data one cycle after address sampled
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) mem[8'h10] <= 8'hA5;
    if (RAMwren) mem[RAMAddress] <= RAMDin;
    RAMq <= mem[RAMAddress];
  end

  typedef struct packed {
    logic [1:0] acq;
    logic [7:0] dq;
  } exp_t;

  exp_t expq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input int core, input logic [7:0] dq);
    exp_t e;
    e.acq = 2'b01 << core;
    e.dq  = dq;
    expq.push_back(e);
  endtask

  // Monitor: every ack seen pops the oldest expectation
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (acq !== 2'b00) begin
        if (expq.size() == 0) begin
          chk("unexpected_ack", {30'd0, acq}, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("ack_core", {30'd0, acq}, {30'd0, mon_e.acq});
          chk("ack_dq", {24'd0, Dq}, {24'd0, mon_e.dq});
        end
      end
    end
  end

  // One transaction on a core; inputs driven on the falling edge before edge 0
  task automatic do_txn(input int core, input bit rd, input bit wr,
                        input logic [7:0] addr, input logic [7:0] din,
                        input logic [7:0] exp_dq, input bit drop_early);
    int  wcnt;
    bit  got;
    Address[core*8 +: 8] = addr;
    Din[core*8 +: 8]     = din;
    rden[core]           = rd;
    wren[core]           = wr;
    push_exp(core, exp_dq);
    wcnt = 0;
    got  = 1'b0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("access_addr", {24'd0, RAMAddress}, {24'd0, addr});
        if (wr) chk("access_din", {24'd0, RAMDin}, {24'd0, din});
        if (drop_early) begin
          rden[core] = 1'b0;
          wren[core] = 1'b0;
        end
      end
      if (RAMwren) wcnt++;
      if (acq !== 2'b00) begin
        got = 1'b1;
        chk("ack_latency", n, 3);
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    chk("wren_cycles", wcnt, wr ? 1 : 0);
    rden[core] = 1'b0;
    wren[core] = 1'b0;
    @(negedge clk);
  endtask

  int extra;
  int acks;
  int last_ack;
  int first_ack;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_acq", {30'd0, acq}, 32'd0);
    chk("rst_dq", {24'd0, Dq}, 32'd0);
    chk("rst_addr", {24'd0, RAMAddress}, 32'd0);
    chk("rst_din", {24'd0, RAMDin}, 32'd0);
    chk("rst_wren", {31'd0, RAMwren}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_txn(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    do_txn(1, 1'b0, 1'b1, 8'h20, 8'h3C, 8'hA5, 1'b0);
    do_txn(1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b0);
    do_txn(0, 1'b1, 1'b1, 8'h05, 8'h77, 8'h3C, 1'b0);
    chk("mem05_written", {24'd0, mem[8'h05]}, 32'h77);
    do_txn(0, 1'b1, 1'b0, 8'h05, 8'h00, 8'h77, 1'b0);

    do_txn(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (acq !== 2'b00) extra++;
    end
    chk("no_reissue", extra, 0);

    Address[7:0] = 8'h05;
    rden[0]      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_acq", {30'd0, acq}, 32'd0);
    chk("midrst_wren", {31'd0, RAMwren}, 32'd0);
    chk("midrst_dq", {24'd0, Dq}, 32'd0);

    Address = {8'h20, 8'h10};
    rden    = 2'b11;
    push_exp(0, 8'hA5);
    push_exp(1, 8'h3C);
    push_exp(0, 8'hA5);
    push_exp(1, 8'h3C);
    rst       = 1'b0;
    acks      = 0;
    last_ack  = 0;
    first_ack = 0;
    for (int c = 1; c <= 30 && acks < 4; c++) begin
      @(negedge clk);
      if (acq !== 2'b00) begin
        if (acks == 0) first_ack = c;
        else chk("ack_spacing", c - last_ack, 4);
        last_ack = c;
        acks++;
        if (acks == 4) rden = 2'b00;
      end
    end
    chk("contention_acks", acks, 4);
    chk("contention_first", first_ack, 3);
    repeat (6) @(negedge clk);
    chk("queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
